// File: rtl/mips_hazard_scoreboard.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline: forwarding selects, load-use
// bubbles, redirect flushes and slow-memory freeze. Define HAZ_PERF_EN to add perf counters.
module mips_hazard_scoreboard #(
    parameter int RA_W         = 5,
    parameter int LOAD_USE_CYC = 1,
    parameter int CNT_W        = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic [RA_W-1:0] id_wreg,
    input  logic            id_regwrite,
    input  logic            id_is_load,
    input  logic            redirect,
    input  logic            mem_busy,
    output logic            stall_if,
    output logic            bubble_ex,
    output logic            flush_ifid,
    output logic            freeze,
    output logic            fwd_id_a,
    output logic            fwd_id_b,
    output logic [1:0]      fwd_ex_a,
    output logic [1:0]      fwd_ex_b
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt,
    output logic [31:0]     perf_freeze_cnt
`endif
);

    // With a single bubble the load has reached WB by the time its consumer enters EX, so a
    // load sitting in MEM only holds the consumer when more bubbles are configured.
    localparam logic MEM_LU = (LOAD_USE_CYC > 1);

    logic            ex_v, ex_use_rs, ex_use_rt, ex_rw, ex_ld;
    logic [RA_W-1:0] ex_rs, ex_rt, ex_wreg;
    logic            mem_v, mem_rw, mem_ld;
    logic [RA_W-1:0] mem_wreg;
    logic            wb_v, wb_rw;
    logic [RA_W-1:0] wb_wreg;
    logic [CNT_W-1:0] bcnt;

    logic lu, ld_ex_hit, ld_mem_hit;
    logic mem_a, mem_b, wb_a, wb_b;

    function automatic logic wr(input logic v, input logic rw,
                                input logic [RA_W-1:0] wreg, input logic [RA_W-1:0] r);
        return v & rw & (wreg == r) & (r != '0);
    endfunction

    assign mem_a = wr(mem_v, mem_rw, mem_wreg, ex_rs) & ex_use_rs & ~mem_ld;
    assign mem_b = wr(mem_v, mem_rw, mem_wreg, ex_rt) & ex_use_rt & ~mem_ld;
    assign wb_a  = wr(wb_v, wb_rw, wb_wreg, ex_rs);
    assign wb_b  = wr(wb_v, wb_rw, wb_wreg, ex_rt);

    assign fwd_ex_a = reset ? 2'b00 : mem_a ? 2'b01 : wb_a ? 2'b10 : 2'b00;
    assign fwd_ex_b = reset ? 2'b00 : mem_b ? 2'b01 : wb_b ? 2'b10 : 2'b00;
    assign fwd_id_a = ~reset & wr(wb_v, wb_rw, wb_wreg, id_rs) & id_use_rs;
    assign fwd_id_b = ~reset & wr(wb_v, wb_rw, wb_wreg, id_rt) & id_use_rt;

    assign ld_ex_hit  = ex_v & ex_ld &
                        (wr(ex_v, ex_rw, ex_wreg, id_rs) & id_use_rs |
                         wr(ex_v, ex_rw, ex_wreg, id_rt) & id_use_rt);
    assign ld_mem_hit = MEM_LU & mem_v & mem_ld &
                        (wr(mem_v, mem_rw, mem_wreg, id_rs) & id_use_rs |
                         wr(mem_v, mem_rw, mem_wreg, id_rt) & id_use_rt);
    assign lu = id_valid & (ld_ex_hit | ld_mem_hit);

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        stall_if   = 1'b0;
        bubble_ex  = 1'b0;
        flush_ifid = 1'b0;
        freeze     = 1'b0;
        if (reset) begin
            stall_if = 1'b0;
        end else if (mem_busy) begin
            freeze   = 1'b1;
            stall_if = 1'b1;
        end else if (redirect) begin
            flush_ifid = 1'b1;
            bubble_ex  = 1'b1;
        end else if (lu || bcnt != '0) begin
            stall_if  = 1'b1;
            bubble_ex = 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so EX, MEM and WB all shift on the
    // same edge from their pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_v <= 1'b0; ex_rs <= '0; ex_rt <= '0; ex_use_rs <= 1'b0; ex_use_rt <= 1'b0;
            ex_wreg <= '0; ex_rw <= 1'b0; ex_ld <= 1'b0;
            mem_v <= 1'b0; mem_wreg <= '0; mem_rw <= 1'b0; mem_ld <= 1'b0;
            wb_v <= 1'b0; wb_wreg <= '0; wb_rw <= 1'b0;
            bcnt <= '0;
        end else if (!freeze) begin
            ex_v      <= id_valid & ~bubble_ex;
            ex_rs     <= id_rs;
            ex_rt     <= id_rt;
            ex_use_rs <= id_use_rs;
            ex_use_rt <= id_use_rt;
            ex_wreg   <= id_wreg;
            ex_rw     <= id_regwrite;
            ex_ld     <= id_is_load;
            mem_v     <= ex_v;
            mem_wreg  <= ex_wreg;
            mem_rw    <= ex_rw;
            mem_ld    <= ex_ld;
            wb_v      <= mem_v;
            wb_wreg   <= mem_wreg;
            wb_rw     <= mem_rw;
            if (redirect)
                bcnt <= '0;
            else if (bcnt == '0)
                bcnt <= lu ? CNT_W'(LOAD_USE_CYC - 1) : '0;
            else
                bcnt <= bcnt - CNT_W'(1);
        end
    end

`ifdef HAZ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt  <= '0;
            perf_flush_cnt  <= '0;
            perf_freeze_cnt <= '0;
        end else begin
            if (stall_if && !freeze && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (flush_ifid && perf_flush_cnt != '1)          perf_flush_cnt <= perf_flush_cnt + 32'd1;
            if (freeze && perf_freeze_cnt != '1)             perf_freeze_cnt <= perf_freeze_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// Checks two scoreboards (1 and 3 load-use bubbles) against an instruction-record pipeline model,
// with directed scenarios pinned by literal expectations and a randomized phase.
`timescale 1ns/1ps
module tb_mips_hazard_scoreboard;
    localparam int RA_W = 5;

    typedef struct packed {
        logic       v;
        logic [4:0] rs, rt;
        logic       use_rs, use_rt;
        logic [4:0] wreg;
        logic       rw, ld;
    } rec_t;

    typedef struct packed {
        logic       stall, bubble, flush, freeze, fid_a, fid_b;
        logic [1:0] fex_a, fex_b;
    } out_t;

    logic clk = 1'b0;
    logic reset, id_valid, id_use_rs, id_use_rt, id_regwrite, id_is_load, redirect, mem_busy;
    logic [RA_W-1:0] id_rs, id_rt, id_wreg;

    logic s1, b1, f1, z1, ia1, ib1, s3, b3, f3, z3, ia3, ib3;
    logic [1:0] xa1, xb1, xa3, xb3;
    out_t o1, o3;
    assign o1 = {s1, b1, f1, z1, ia1, ib1, xa1, xb1};
    assign o3 = {s3, b3, f3, z3, ia3, ib3, xa3, xb3};

`ifdef HAZ_PERF_EN
    logic [2:0][31:0] perf_d1, perf_d3, perf_m1, perf_m3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_hazard_scoreboard #(.RA_W(RA_W), .LOAD_USE_CYC(1), .CNT_W(2)) u1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load), .redirect(redirect),
        .mem_busy(mem_busy), .stall_if(s1), .bubble_ex(b1), .flush_ifid(f1), .freeze(z1),
        .fwd_id_a(ia1), .fwd_id_b(ib1), .fwd_ex_a(xa1), .fwd_ex_b(xb1)
`ifdef HAZ_PERF_EN
        , .perf_stall_cnt(perf_d1[0]), .perf_flush_cnt(perf_d1[1]), .perf_freeze_cnt(perf_d1[2])
`endif
    );

    mips_hazard_scoreboard #(.RA_W(RA_W), .LOAD_USE_CYC(3), .CNT_W(2)) u3 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load), .redirect(redirect),
        .mem_busy(mem_busy), .stall_if(s3), .bubble_ex(b3), .flush_ifid(f3), .freeze(z3),
        .fwd_id_a(ia3), .fwd_id_b(ib3), .fwd_ex_a(xa3), .fwd_ex_b(xb3)
`ifdef HAZ_PERF_EN
        , .perf_stall_cnt(perf_d3[0]), .perf_flush_cnt(perf_d3[1]), .perf_freeze_cnt(perf_d3[2])
`endif
    );

    // Model: index 0 = instruction in EX, 1 = MEM, 2 = WB; 'left' = bubbles still owed.
    rec_t [2:0] p1, p3;
    int left1, left3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic writes(input rec_t s, input logic [4:0] r);
        return s.v && s.rw && s.wreg == r && r != 5'd0;
    endfunction

    function automatic logic [1:0] ex_sel(input rec_t [2:0] p, input logic [4:0] r, input logic use_r);
        if (writes(p[1], r) && use_r && !p[1].ld) return 2'b01;
        if (writes(p[2], r)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic waits_on(input rec_t s, input rec_t id);
        return s.v && s.ld && ((writes(s, id.rs) && id.use_rs) || (writes(s, id.rt) && id.use_rt));
    endfunction

    function automatic logic lu_of(input rec_t [2:0] p, input int cyc, input rec_t id);
        return id.v && (waits_on(p[0], id) || (cyc > 1 && waits_on(p[1], id)));
    endfunction

    function automatic out_t expect_out(input rec_t [2:0] p, input int left, input int cyc,
                                        input rec_t id, input logic rst, input logic busy,
                                        input logic redir);
        out_t e = '0;
        if (rst) return e;
        e.fex_a = ex_sel(p, p[0].rs, p[0].use_rs);
        e.fex_b = ex_sel(p, p[0].rt, p[0].use_rt);
        e.fid_a = writes(p[2], id.rs) && id.use_rs;
        e.fid_b = writes(p[2], id.rt) && id.use_rt;
        if (busy) begin
            e.freeze = 1'b1; e.stall = 1'b1;
        end else if (redir) begin
            e.flush = 1'b1; e.bubble = 1'b1;
        end else if (lu_of(p, cyc, id) || left > 0) begin
            e.stall = 1'b1; e.bubble = 1'b1;
        end
        return e;
    endfunction

    task automatic advance(input int cyc, input rec_t id, input out_t e,
                           inout rec_t [2:0] p, inout int left);
        logic l;
        if (reset) begin
            p = '0; left = 0;
        end else if (!mem_busy) begin
            l = lu_of(p, cyc, id);
            if (redirect)       left = 0;
            else if (left == 0) left = l ? cyc - 1 : 0;
            else                left = left - 1;
            p[2] = p[1];
            p[1] = p[0];
            p[0] = id;
            p[0].v = id.v && !e.bubble;
        end
    endtask

`ifdef HAZ_PERF_EN
    function automatic logic [2:0][31:0] perf_next(input logic [2:0][31:0] m, input out_t e,
                                                   input logic rst);
        logic [2:0][31:0] n = m;
        if (rst) return '0;
        if (e.stall && !e.freeze && n[0] != 32'hFFFF_FFFF) n[0] = n[0] + 1;
        if (e.flush && n[1] != 32'hFFFF_FFFF) n[1] = n[1] + 1;
        if (e.freeze && n[2] != 32'hFFFF_FFFF) n[2] = n[2] + 1;
        return n;
    endfunction
`endif

    function automatic rec_t cur_id();
        rec_t r;
        r.v = id_valid; r.rs = id_rs; r.rt = id_rt; r.use_rs = id_use_rs; r.use_rt = id_use_rt;
        r.wreg = id_wreg; r.rw = id_regwrite; r.ld = id_is_load;
        return r;
    endfunction

    // Compare with settled inputs, then advance the model across the clock edge.
    task automatic step();
        rec_t id;
        out_t e1, e3;
        id = cur_id();
        e1 = expect_out(p1, left1, 1, id, reset, mem_busy, redirect);
        e3 = expect_out(p3, left3, 3, id, reset, mem_busy, redirect);
        check("model_c1", 32'(o1), 32'(e1));
        check("model_c3", 32'(o3), 32'(e3));
`ifdef HAZ_PERF_EN
        for (int k = 0; k < 3; k++) begin
            check("perf_c1", perf_d1[k], perf_m1[k]);
            check("perf_c3", perf_d3[k], perf_m3[k]);
        end
`endif
        @(posedge clk);
        advance(1, id, e1, p1, left1);
        advance(3, id, e3, p3, left3);
`ifdef HAZ_PERF_EN
        perf_m1 = perf_next(perf_m1, e1, reset);
        perf_m3 = perf_next(perf_m3, e3, reset);
`endif
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic [4:0] w,
                          input logic rw, input logic ld);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_wreg = w; id_regwrite = rw; id_is_load = ld;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic go();
        #1;
        step();
    endtask

    task automatic drain();
        redirect = 1'b0; mem_busy = 1'b0; reset = 1'b0;
        nop();
        repeat (3) go();
    endtask

    // lw $2,0($0) and a consumer add $4,$2,$2
    task automatic lw2();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);
    endtask
    task automatic use2();
        set_id(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c1, c3;
        p1 = '0; p3 = '0; left1 = 0; left3 = 0;
`ifdef HAZ_PERF_EN
        perf_m1 = '0; perf_m3 = '0;
`endif
        reset = 1'b1; redirect = 1'b0; mem_busy = 1'b0;
        nop();
        @(negedge clk);
        go(); go();
        reset = 1'b0;
        #1;
        check("reset_c1", 32'(o1), 0);
        check("reset_c3", 32'(o3), 0);
        step();

        // ALU result forwarded from EX/MEM, no stall
        drain();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0); go();
        set_id(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0); #1;
        check("alu_nostall_c1", 32'(s1), 0);
        check("alu_nostall_c3", 32'(s3), 0);
        step();
        nop(); #1;
        check("alu_fwd_a_c1", 32'(xa1), 32'h1);
        check("alu_fwd_b_c1", 32'(xb1), 32'h0);
        check("alu_fwd_a_c3", 32'(xa3), 32'h1);
        step();

        // load-use: one bubble vs three bubbles, then WB forwarding
        drain();
        lw2(); go();
        c1 = 0; c3 = 0;
        for (int i = 0; i < 4; i++) begin
            use2(); #1;
            if (s1 && b1) c1++;
            if (s3 && b3) c3++;
            if (i == 2) begin
                check("lu_fwd_a_c1", 32'(xa1), 32'h2);
                check("lu_fwd_b_c1", 32'(xb1), 32'h2);
            end
            step();
        end
        check("lu_bubbles_c1", 32'(c1), 1);
        check("lu_bubbles_c3", 32'(c3), 3);

        // register $0 never hazards or forwards
        drain();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0); go();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); #1;
        check("r0_nostall_c1", 32'(s1), 0);
        step();
        nop(); #1;
        check("r0_fwd_c1", 32'({xa1, xb1}), 0);
        check("r0_fwd_c3", 32'({xa3, xb3}), 0);
        step();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1); go();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); #1;
        check("r0_load_nostall_c3", 32'(s3), 0);
        step();

        // redirect wins over load-use and clears the bubble counter
        drain();
        lw2(); go();
        use2(); redirect = 1'b1; #1;
        check("redir_flush_c3", 32'(f3), 1);
        check("redir_stall_c3", 32'(s3), 0);
        check("redir_bubble_c3", 32'(b3), 1);
        step();
        redirect = 1'b0; nop(); #1;
        check("redir_cnt_clear_c3", 32'(s3), 0);
        step();

        // slow memory freezes everything; the load-use outcome is unchanged
        drain();
        lw2(); go();
        use2(); mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("busy_freeze_c1", 32'({z1, s1, b1, f1}), 32'hC);
            step();
        end
        mem_busy = 1'b0;
        c1 = 0; c3 = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (s1) c1++;
            if (s3) c3++;
            step();
        end
        check("busy_bubbles_c1", 32'(c1), 1);
        check("busy_bubbles_c3", 32'(c3), 3);

        // reset in the middle of a 3-bubble stall
        drain();
        lw2(); go();
        use2(); go();
        reset = 1'b1; go();
        reset = 1'b0; #1;
        check("rst_mid_c3", 32'(o3), 0);
`ifdef HAZ_PERF_EN
        check("rst_mid_perf_c3", perf_d3[0] | perf_d3[1] | perf_d3[2], 0);
`endif
        step();

        // randomized phase over a small register window to provoke hazards
        drain();
        for (int n = 0; n < 3000; n++) begin
            set_id($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                   $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3);
            redirect = $urandom_range(0, 9) == 0;
            mem_busy = $urandom_range(0, 99) < 15;
            reset    = $urandom_range(0, 99) == 0;
            go();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
